// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package subtrator_serial_pkg;
    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;
endpackage

// File: rtl/subtrator_1bit.sv
// Combinational full-subtractor cell: D = X - Y - BE, BS is the borrow out.
module subtrator_1bit (
    input  logic X,
    input  logic Y,
    input  logic BE,
    output logic D,
    output logic BS
);
    assign D  = X ^ Y ^ BE;
    assign BS = (~X & Y) | (~X & BE) | (Y & BE);
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: A - B processed LSB-first, one bit per clock,
// through a single full-subtractor cell with a registered borrow.
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ocupado,
    output logic         pronto,
    output logic [N-1:0] D,
    output logic         SB
);
    localparam int              CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   ULTIMO = CW'(N - 1);

    estado_t         r_estado;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_d;
    logic [CW-1:0]   r_cnt;
    logic            r_borrow;
    logic            r_sb;
    logic            r_ocupado;
    logic            r_pronto;
    logic            w_d;
    logic            w_bs;

    subtrator_1bit u_cell (
        .X  (r_a[0]),
        .Y  (r_b[0]),
        .BE (r_borrow),
        .D  (w_d),
        .BS (w_bs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= OCIOSO;
            r_a       <= '0;
            r_b       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_borrow  <= 1'b0;
            r_sb      <= 1'b0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_pronto <= 1'b0;
                    if (inicio) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_borrow  <= 1'b0;
                        r_cnt     <= '0;
                        r_ocupado <= 1'b1;
                        r_estado  <= CALCULA;
                    end
                end
                CALCULA: begin
                    // Difference bits enter at the MSB so bit 0 lands in D[0] after N shifts.
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_d      <= {w_d, r_d[N-1:1]};
                    r_borrow <= w_bs;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == ULTIMO) begin
                        r_sb      <= w_bs;
                        r_ocupado <= 1'b0;
                        r_pronto  <= 1'b1;
                        r_estado  <= FIM;
                    end
                end
                FIM: begin
                    r_pronto <= 1'b0;
                    r_estado <= OCIOSO;
                end
                default: begin
                    r_ocupado <= 1'b0;
                    r_pronto  <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign ocupado = r_ocupado;
    assign pronto  = r_pronto;
    assign D       = r_d;
    assign SB      = r_sb;
endmodule

// File: tb/tb_subtrator_serial.sv
// Directed bench for subtrator_serial: N=4 instance for most scenarios, N=8 for the wide regression.
module tb_subtrator_serial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inicio = 1'b0;
    logic [3:0] A = '0, B = '0;
    logic       ocupado, pronto, SB;
    logic [3:0] D;

    logic       inicio8 = 1'b0;
    logic [7:0] A8 = '0, B8 = '0;
    logic       ocupado8, pronto8, SB8;
    logic [7:0] D8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subtrator_serial #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .A(A), .B(B),
        .ocupado(ocupado), .pronto(pronto), .D(D), .SB(SB)
    );

    subtrator_serial #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio8), .A(A8), .B(B8),
        .ocupado(ocupado8), .pronto(pronto8), .D(D8), .SB(SB8)
    );

    // Runs one N=4 operation; reports pronto latency (negedges after accept), busy count, overlap and result.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output int busy, output int overlap,
                         output logic [3:0] d, output logic sb);
        lat = -1; busy = 0; overlap = 0; d = 'x; sb = 1'bx;
        @(negedge clk);
        A = a; B = b; inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        A = ~a; B = ~b;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            if (ocupado) busy++;
            if (ocupado && pronto) overlap++;
            if (pronto) begin
                lat = i; d = D; sb = SB;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({ocupado, pronto, D, SB} !== 7'b0) begin
            errors++;
            $display("FAIL reset_n4: ocupado=%b pronto=%b D=%h SB=%b, required all 0", ocupado, pronto, D, SB);
        end
        checks++;
        if ({ocupado8, pronto8, D8, SB8} !== 11'b0) begin
            errors++;
            $display("FAIL reset_n8: ocupado=%b pronto=%b D=%h SB=%b, required all 0", ocupado8, pronto8, D8, SB8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, busy, ov; logic [3:0] d; logic sb;
        do_op(4'd9, 4'd3, lat, busy, ov, d, sb);
        checks++;
        if (busy !== 4 || lat !== 5 || ov !== 0) begin
            errors++;
            $display("FAIL basic_timing: busy=%0d lat=%0d overlap=%0d, required 4/5/0", busy, lat, ov);
        end
        checks++;
        if (d !== 4'b0110 || sb !== 1'b0) begin
            errors++;
            $display("FAIL basic_9m3: D=%h SB=%b, required 6/0", d, sb);
        end
        // Result must persist while idle.
        repeat (3) @(negedge clk);
        checks++;
        if (D !== 4'b0110 || SB !== 1'b0 || pronto !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: D=%h SB=%b pronto=%b ocupado=%b, required 6/0/0/0", D, SB, pronto, ocupado);
        end
    endtask

    task automatic test_borrow;
        int lat, busy, ov; logic [3:0] d; logic sb;
        do_op(4'd3, 4'd9, lat, busy, ov, d, sb);
        checks++;
        if (lat !== 5 || d !== 4'b1010 || sb !== 1'b1) begin
            errors++;
            $display("FAIL borrow_3m9: lat=%0d D=%h SB=%b, required 5/a/1", lat, d, sb);
        end
    endtask

    task automatic test_boundaries;
        logic [3:0] ta[3] = '{4'd0, 4'd15, 4'd15};
        logic [3:0] tb_[3] = '{4'd1, 4'd15, 4'd0};
        logic [3:0] td[3] = '{4'hF, 4'h0, 4'hF};
        logic       ts[3] = '{1'b1, 1'b0, 1'b0};
        int lat, busy, ov; logic [3:0] d; logic sb;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb_[i], lat, busy, ov, d, sb);
            checks++;
            if (lat !== 5 || d !== td[i] || sb !== ts[i]) begin
                errors++;
                $display("FAIL boundary_%0d_minus_%0d: lat=%0d D=%h SB=%b, required 5/%h/%b",
                         ta[i], tb_[i], lat, d, sb, td[i], ts[i]);
            end
        end
    endtask

    // inicio held high, operands changing every cycle: accepts at edges 0 and 6, pronto after edges 4 and 10.
    task automatic test_back_to_back;
        logic exp_p;
        @(negedge clk);
        inicio = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            A = 4'(c + 1);
            B = 4'(3 * c + 2);
            @(posedge clk);
            @(negedge clk);
            exp_p = (c == 4) || (c == 10);
            checks++;
            if (pronto !== exp_p || (pronto && ocupado)) begin
                errors++;
                $display("FAIL b2b_pronto_c%0d: pronto=%b ocupado=%b, required pronto=%b", c, pronto, ocupado, exp_p);
            end
            if (c == 4) begin
                checks++;
                if (D !== 4'hF || SB !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first_1m2: D=%h SB=%b, required f/1", D, SB);
                end
            end
            if (c == 10) begin
                checks++;
                if (D !== 4'h3 || SB !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_7m4: D=%h SB=%b, required 3/0", D, SB);
                end
            end
        end
        inicio = 1'b0;
    endtask

    task automatic test_async_reset;
        int lat, busy, ov, seen; logic [3:0] d; logic sb;
        @(negedge clk);
        A = 4'd5; B = 4'd7; inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({ocupado, pronto, D, SB} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset_clear: ocupado=%b pronto=%b D=%h SB=%b, required all 0", ocupado, pronto, D, SB);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (pronto || ocupado) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL async_reset_abort: %0d cycles with pronto/ocupado, required 0", seen);
        end
        do_op(4'd7, 4'd5, lat, busy, ov, d, sb);
        checks++;
        if (lat !== 5 || d !== 4'd2 || sb !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_recover_7m5: lat=%0d D=%h SB=%b, required 5/2/0", lat, d, sb);
        end
    endtask

    task automatic test_n8;
        int lat = -1, busy = 0;
        @(negedge clk);
        A8 = 8'h00; B8 = 8'h01; inicio8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio8 = 1'b0; A8 = 8'h5A; B8 = 8'hA5;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            if (ocupado8) busy++;
            if (pronto8) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 9 || busy !== 8) begin
            errors++;
            $display("FAIL n8_timing: lat=%0d busy=%0d, required 9/8", lat, busy);
        end
        checks++;
        if (D8 !== 8'hFF || SB8 !== 1'b1) begin
            errors++;
            $display("FAIL n8_0m1: D=%h SB=%b, required ff/1", D8, SB8);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (D8 !== 8'hFF || SB8 !== 1'b1 || pronto8 !== 1'b0) begin
            errors++;
            $display("FAIL n8_hold: D=%h SB=%b pronto=%b, required ff/1/0", D8, SB8, pronto8);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_boundaries();
        test_back_to_back();
        test_async_reset();
        test_n8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/subtrator_serial.md
Name: subtrator_serial

Overview:
Bit-serial N-bit subtractor, the inverse operation of the team's full-adder datapath. It accepts two operands on a start pulse and computes A − B LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow. It presents the difference, the final borrow and a one-cycle completion pulse. It sits between the lab switch/operand registers and the 7-segment display decoder path.

Parameters:
N, 4, operand and difference width in bits (minimum 2).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  reset; asynchronous, active-low.
inicio  input  1  start request; sampled only in state OCIOSO.
A  input  N  minuend; captured on the accepted start.
B  input  N  subtrahend; captured on the accepted start.
ocupado  output  1  high while a subtraction is in progress (state CALCULA).
pronto  output  1  one-cycle pulse: D and SB are valid.
D  output  N  difference A − B modulo 2^N.
SB  output  1  borrow out; 1 when A < B (unsigned).

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=OCIOSO, ocupado=0, pronto=0, D=0, SB=0, internal shift registers, borrow and bit counter=0.
  - Reset mid-operation aborts the operation. No pronto is issued.
- States: OCIOSO, CALCULA, FIM.
- OCIOSO:
  - If inicio=1 at an edge: capture A and B into shift registers, clear borrow, clear the counter (width ceil(log2 N)), go to CALCULA.
  - D and SB keep their last values.
- CALCULA, one bit per edge, bit i = counter:
  - d = a_i ^ b_i ^ bin
  - bout = (~a_i & b_i) | (~a_i & bin) | (b_i & bin)
  - d is shifted into the D register from the MSB end, so that after N shifts bit 0 sits at D[0].
  - The borrow register is updated with bout.
  - On the edge processing bit N−1: go to FIM, load SB with that bout, and update D with the final bit.
- FIM: pronto=1 for exactly this one cycle. Next edge goes to OCIOSO unconditionally.
- Latency: if inicio is accepted at edge k, the bits are processed at edges k+1..k+N and pronto is high between edges k+N and k+N+1. Total N+1 cycles. Throughput is one operation per N+2 cycles.
- ocupado=1 exactly while in CALCULA. pronto and ocupado are never high at the same time.
- inicio while in CALCULA or FIM is ignored (no queueing).
- A and B may change after acceptance without affecting the result.
- D and SB must not glitch outside CALCULA/FIM. They hold valid values from pronto until the next accepted inicio.
- During CALCULA, D holds partial shift contents and is not valid.
- Arithmetic is unsigned and modulo 2^N. SB is the true borrow, so {SB,D} read as signed N+1 bits equals A − B.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared include file (subtrator_defs.vh): state encoding localparams OCIOSO=2'd0, CALCULA=2'd1, FIM=2'd2, plus the default width N.
- One natural sub-module: subtrator_1bit.
  - Purely combinational full-subtractor cell.
  - Inputs X, Y, BE (borrow in); outputs D, BS (borrow out).
  - Mirrors the existing full-adder cell; instantiated once.
- The FSM, counter and shift registers live in the top module.

Test Plan:
- Reset, then A=9, B=3, inicio for one cycle -> ocupado high for 4 cycles, then pronto for 1 cycle with D=4'b0110 (6), SB=0.
- A=3, B=9 -> D=4'b1010 (10), SB=1, pronto 5 cycles after the accepted inicio edge.
- Boundary values:
  - A=0, B=1 -> D=4'b1111, SB=1.
  - A=15, B=15 -> D=0, SB=0.
  - A=15, B=0 -> D=15, SB=0.
- inicio held high continuously, with A/B changed every cycle -> result matches the operands captured at acceptance. The next operation starts only after returning to OCIOSO, one pronto per N+2 cycles.
- rst_n pulled low asynchronously (between clock edges) during bit 2 of 5−7 -> outputs go to 0 immediately, with no pronto. After release, a new 7−5 yields D=2, SB=0.
- N=8 regression: A=8'h00, B=8'h01 -> D=8'hFF, SB=1, pronto 9 cycles after acceptance; D stays stable until the next inicio.
